// File: rtl/sort_cmp_if.sv
// Valid/ready streams and status of the block sorter, grouped for the sorter ports.
// The master modport is the source/consumer side; the slave modport is the sorter.
interface sort_cmp_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic [5:0]       swap_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, swap_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, swap_cnt
    );
endinterface

// File: rtl/sort_cmp_ctrl.sv
// Block bubble sorter: loads DEPTH words, sorts them ascending with one shared comparator
// (one compare per cycle), then drains them. Define SORT_EARLY_EXIT_EN to stop after a swap-free pass.
module sort_cmp_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    sort_cmp_if.slave  bus
);
    localparam int            IW      = $clog2(DEPTH);
    localparam logic [IW-1:0] LASTIDX = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LASTPOS = IW'(DEPTH - 2);

`ifdef SORT_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {ST_LOAD, ST_SORT, ST_DRAIN} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_bank [DEPTH];
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    r_pass;
    logic [IW-1:0]    r_pos;
    logic             r_pass_swp;
    logic [5:0]       r_swap_cnt;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_gt;
    logic             w_pass_end;
    logic             w_sort_done;
    logic             w_in_fire;
    logic             w_out_fire;

    // The single shared comparator always looks at the current adjacent pair.
    assign w_a         = r_bank[r_pos];
    assign w_b         = r_bank[r_pos + IW'(1)];
    assign w_gt        = (w_a > w_b);
    assign w_pass_end  = (r_pos == (LASTPOS - r_pass));
    assign w_sort_done = w_pass_end &&
                         ((r_pass == LASTPOS) || (EARLY_EXIT && !(r_pass_swp || w_gt)));
    assign w_in_fire   = (r_state == ST_LOAD) && bus.in_valid;
    assign w_out_fire  = (r_state == ST_DRAIN) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.busy      = 1'b0;
        bus.out_data  = r_bank[r_idx];
        bus.swap_cnt  = r_swap_cnt;
        case (r_state)
            ST_LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && (r_idx == LASTIDX)) w_next = ST_SORT;
            end
            ST_SORT: begin
                bus.busy = 1'b1;
                if (w_sort_done) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_last  = (r_idx == LASTIDX);
                if (bus.out_ready && (r_idx == LASTIDX)) w_next = ST_LOAD;
            end
            default: w_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
            r_idx      <= '0;
            r_pass     <= '0;
            r_pos      <= '0;
            r_pass_swp <= 1'b0;
            r_swap_cnt <= '0;
        end else begin
            if (w_in_fire) begin
                r_bank[r_idx] <= bus.in_data;
                r_idx         <= (r_idx == LASTIDX) ? '0 : r_idx + IW'(1);
                r_pass        <= '0;
                r_pos         <= '0;
                r_pass_swp    <= 1'b0;
                if (r_idx == '0) r_swap_cnt <= '0;
            end
            if (r_state == ST_SORT) begin
                if (w_gt) begin
                    r_bank[r_pos]          <= w_b;
                    r_bank[r_pos + IW'(1)] <= w_a;
                    r_swap_cnt             <= r_swap_cnt + 6'd1;
                end
                // A pass ends at the shrinking boundary; the swap flag restarts per pass.
                if (w_pass_end) begin
                    r_pos      <= '0;
                    r_pass     <= w_sort_done ? '0 : r_pass + IW'(1);
                    r_pass_swp <= 1'b0;
                end else begin
                    r_pos      <= r_pos + IW'(1);
                    r_pass_swp <= r_pass_swp | w_gt;
                end
            end
            if (w_out_fire) begin
                r_idx <= (r_idx == LASTIDX) ? '0 : r_idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_sort_cmp_ctrl.sv
// Scoreboard bench for sort_cmp_ctrl (DEPTH=4, WIDTH=4); expectations come from a
// reference sort and an inversion count of each loaded block.
module tb_sort_cmp_ctrl;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
`ifdef SORT_EARLY_EXIT_EN
    localparam int SORTED_CYC = 3;
`else
    localparam int SORTED_CYC = 6;
`endif

    typedef logic [WIDTH-1:0] blk_t [DEPTH];

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sort_cmp_if #(.WIDTH(WIDTH)) bus ();

    sort_cmp_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int               n_vec = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] exp_q [$];
    int               exp_swaps = 0;

    task automatic load_block(input blk_t w);
        blk_t s;
        logic [WIDTH-1:0] t;
        int g;
        s = w;
        exp_swaps = 0;
        for (int i = 0; i < DEPTH; i++)
            for (int j = i + 1; j < DEPTH; j++)
                if (w[i] > w[j]) exp_swaps++;
        for (int i = 1; i < DEPTH; i++)
            for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
                t = s[j]; s[j] = s[j-1]; s[j-1] = t;
            end
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(s[i]);
        for (int i = 0; i < DEPTH; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[i];
            g = 0;
            while (bus.in_ready !== 1'b1 && g < 50) begin
                @(posedge clk); #1; g++;
            end
            if (g >= 50) begin
                n_err++;
                $display("FAIL load_ready: in_ready=%b required 1 within 50 cycles", bus.in_ready);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic measure_sort(input string name, input int exp_cyc);
        int c = 0;
        while (bus.out_valid !== 1'b1 && c < 100) begin
            n_vec++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL %s_sort_ctrl: in_ready=%b busy=%b required 0/1", name, bus.in_ready, bus.busy);
            end
            @(posedge clk); #1; c++;
        end
        n_vec++;
        if (c != exp_cyc) begin
            n_err++;
            $display("FAIL %s_sort_cycles: got %0d required %0d", name, c, exp_cyc);
        end
    endtask

    task automatic drain_block(input string name, input int stall_at, input int stall_len);
        logic [WIDTH-1:0] e;
        int k = 0;
        int g = 0;
        int rem = stall_len;
        while (exp_q.size() > 0 && g < 200) begin
            g++;
            if (k == stall_at && rem > 0) begin
                bus.out_ready = 1'b0;
                @(posedge clk); #1;
                rem--;
                n_vec++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL %s_stall: valid=%b data=%0d required 1/%0d", name, bus.out_valid, bus.out_data, exp_q[0]);
                end
                continue;
            end
            bus.out_ready = 1'b1;
            if (bus.out_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_vec++;
                if (bus.out_data !== e) begin
                    n_err++;
                    $display("FAIL %s_data[%0d]: got %0d required %0d", name, k, bus.out_data, e);
                end
                n_vec++;
                if (bus.out_last !== (exp_q.size() == 0)) begin
                    n_err++;
                    $display("FAIL %s_last[%0d]: got %b required %b", name, k, bus.out_last, exp_q.size() == 0);
                end
                k++;
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        if (g >= 200) begin
            n_err++;
            $display("FAIL %s_drain_timeout: %0d words left, required 0", name, exp_q.size());
            exp_q.delete();
        end
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_back_to_load: in_ready=%b busy=%b out_valid=%b required 1/0/0", name, bus.in_ready, bus.busy, bus.out_valid);
        end
        n_vec++;
        if (bus.swap_cnt !== 6'(exp_swaps)) begin
            n_err++;
            $display("FAIL %s_swap_cnt: got %0d required %0d", name, bus.swap_cnt, exp_swaps);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b out_last=%b busy=%b required 1/0/0/0", bus.in_ready, bus.out_valid, bus.out_last, bus.busy);
        end
        n_vec++;
        if (bus.swap_cnt !== 6'd0 || bus.out_data !== 4'd0) begin
            n_err++;
            $display("FAIL reset_data: swap_cnt=%0d out_data=%0d required 0/0", bus.swap_cnt, bus.out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mixed();
        load_block('{4'd5, 4'd3, 4'd10, 4'd3});
        measure_sort("mixed", 6);
        drain_block("mixed", -1, 0);
    endtask

    task automatic test_reverse();
        load_block('{4'd15, 4'd14, 4'd13, 4'd12});
        measure_sort("reverse", 6);
        drain_block("reverse", -1, 0);
    endtask

    task automatic test_sorted();
        load_block('{4'd1, 4'd2, 4'd3, 4'd4});
        measure_sort("sorted", SORTED_CYC);
        drain_block("sorted", -1, 0);
    endtask

    task automatic test_backpressure();
        load_block('{4'd6, 4'd9, 4'd0, 4'd12});
        measure_sort("bp", 6);
        drain_block("bp", 2, 5);
    endtask

    task automatic test_ignore_in_sort();
        load_block('{4'd7, 4'd1, 4'd4, 4'd2});
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd9;
        measure_sort("ignore", 6);
        bus.in_valid = 1'b0;
        drain_block("ignore", -1, 0);
        load_block('{4'd2, 4'd2, 4'd1, 4'd1});
        measure_sort("back_to_back", 6);
        drain_block("back_to_back", -1, 0);
    endtask

    task automatic test_reset_mid_sort();
        load_block('{4'd3, 4'd1, 4'd2, 4'd0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.busy !== 1'b0 ||
            bus.swap_cnt !== 6'd0 || bus.out_data !== 4'd0) begin
            n_err++;
            $display("FAIL midsort_reset: in_ready=%b out_valid=%b last=%b busy=%b swap=%0d data=%0d required 1/0/0/0/0/0",
                     bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.swap_cnt, bus.out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_block('{4'd8, 4'd0, 4'd8, 4'd0});
        measure_sort("after_reset", 6);
        drain_block("after_reset", -1, 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_mixed();
        test_reverse();
        test_sorted();
        test_backpressure();
        test_ignore_in_sort();
        test_reset_mid_sort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
